// File: rtl/clk_enable_ctrl_if.sv
// clk_enable_ctrl_if: control/status bundle between the enable controller and its driver
interface clk_enable_ctrl_if #(
   parameter int DIV_WIDTH = 8
);
   logic [DIV_WIDTH-1:0] div;
   logic                 run;
   logic                 halt;
   logic                 step;
   logic                 core_reset;
   logic                 clk_en;
   logic                 running;
   logic [63:0]          cycle_count;
   modport master (output div, run, halt, step, input core_reset, clk_en, running, cycle_count);
   modport slave  (input div, run, halt, step, output core_reset, clk_en, running, cycle_count);
endinterface

// File: rtl/clk_enable_ctrl.sv
// clk_enable_ctrl: core reset sequencing plus divided run/halt/step clock-enable generation
module clk_enable_ctrl #(
   parameter int DIV_WIDTH  = 8,
   parameter int RESET_HOLD = 4
) (
   input logic               clk,
   input logic               reset,
   clk_enable_ctrl_if.slave  bus
);
   localparam int HW = $clog2(RESET_HOLD + 1);
   typedef enum logic [1:0] {INIT, HALTED, RUNNING, STEPPING} state_t;
   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic                 core_reset_q, core_reset_d;
   logic                 clk_en_q, clk_en_d;
   logic                 running_q, running_d;
   logic [63:0]          cycle_count_q, cycle_count_d;
   logic                 hold_done;
   logic                 wrap;
   assign hold_done = hold_q == HW'(RESET_HOLD);
   // div is compared live so a lowered div fires on the next edge
   assign wrap      = cnt_q >= bus.div;
   // state register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= INIT;
         cnt_q         <= '0;
         hold_q        <= '0;
         core_reset_q  <= 1'b1;
         clk_en_q      <= 1'b0;
         running_q     <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hold_q        <= hold_d;
         core_reset_q  <= core_reset_d;
         clk_en_q      <= clk_en_d;
         running_q     <= running_d;
         cycle_count_q <= cycle_count_d;
      end
   end
   // next state, divider count and next output values
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      core_reset_d = 1'b0;
      clk_en_d     = 1'b0;
      case (state_q)
         INIT: begin
            core_reset_d = !hold_done;
            hold_d       = hold_done ? hold_q : hold_q + HW'(1);
            state_d      = hold_done ? HALTED : INIT;
         end
         HALTED: begin
            cnt_d   = '0;
            state_d = bus.halt ? HALTED : bus.run ? RUNNING : bus.step ? STEPPING : HALTED;
         end
         default: begin
            if (bus.halt || (state_q == RUNNING && !bus.run)) begin
               state_d = HALTED;
               cnt_d   = '0;
            end else if (wrap) begin
               cnt_d    = '0;
               clk_en_d = 1'b1;
               state_d  = state_q == STEPPING ? HALTED : RUNNING;
            end else begin
               cnt_d = cnt_q + DIV_WIDTH'(1);
            end
         end
      endcase
      running_d     = state_d == RUNNING || state_d == STEPPING;
      cycle_count_d = clk_en_d ? cycle_count_q + 64'd1 : cycle_count_q;
   end
   assign bus.core_reset  = core_reset_q;
   assign bus.clk_en      = clk_en_q;
   assign bus.running     = running_q;
   assign bus.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_clk_enable_ctrl.sv
// tb_clk_enable_ctrl: vector table, corner sequences and random run against a reference model
module tb_clk_enable_ctrl;
   localparam int RH = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   clk_enable_ctrl_if #(.DIV_WIDTH(8)) bus();
   clk_enable_ctrl #(.DIV_WIDTH(8), .RESET_HOLD(RH)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   // reference model: 0=init 1=halted 2=running 3=stepping
   int          m_mode = 0;
   int          m_rel  = 0;
   int          m_age  = 0;
   logic        m_en   = 1'b0;
   logic [63:0] m_pulses = '0;
   typedef struct {
      logic       rst;
      logic [7:0] div;
      logic       run, halt, step;
      logic       cr, en, rn;
      logic [63:0] cc;
   } vec_t;
   vec_t tbl[24];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask
   task automatic model_edge();
      m_en = 1'b0;
      if (reset) begin
         m_mode = 0; m_rel = 0; m_age = 0; m_pulses = '0;
      end else if (m_mode == 0) begin
         m_rel++;
         if (m_rel > RH) m_mode = 1;
      end else if (m_mode == 1) begin
         m_age  = 0;
         m_mode = bus.halt ? 1 : bus.run ? 2 : bus.step ? 3 : 1;
      end else if (bus.halt || (m_mode == 2 && !bus.run)) begin
         m_mode = 1; m_age = 0;
      end else if (m_age >= int'(bus.div)) begin
         m_en = 1'b1; m_pulses++; m_age = 0;
         if (m_mode == 3) m_mode = 1;
      end else begin
         m_age++;
      end
   endtask
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("m_core_reset", bus.core_reset, m_mode == 0);
      chk("m_clk_en", bus.clk_en, m_en);
      chk("m_running", bus.running, m_mode >= 2);
      chk("m_cycle_count", bus.cycle_count, m_pulses);
   endtask
   initial begin
      bus.div = '0; bus.run = 1'b0; bus.halt = 1'b0; bus.step = 1'b0;
      //            rst div run halt step  cr en rn cc
      tbl[0]  = '{1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[1]  = '{1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[2]  = '{1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[3]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[4]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[5]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[6]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0};
      tbl[7]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0};
      tbl[8]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0};
      tbl[9]  = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0};
      tbl[10] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0};
      tbl[11] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd0};
      tbl[12] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd1};
      tbl[13] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1};
      tbl[14] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1};
      tbl[15] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd1};
      tbl[16] = '{1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'd2};
      tbl[17] = '{1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2};
      tbl[18] = '{1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd2};
      tbl[19] = '{1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd2};
      tbl[20] = '{1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2};
      tbl[21] = '{1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'd2};
      tbl[22] = '{1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd3};
      tbl[23] = '{1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd3};
      for (int i = 0; i < 24; i++) begin
         reset = tbl[i].rst; bus.div = tbl[i].div; bus.run = tbl[i].run;
         bus.halt = tbl[i].halt; bus.step = tbl[i].step;
         tick();
         chk($sformatf("tbl%0d_core_reset", i), bus.core_reset, tbl[i].cr);
         chk($sformatf("tbl%0d_clk_en", i), bus.clk_en, tbl[i].en);
         chk($sformatf("tbl%0d_running", i), bus.running, tbl[i].rn);
         chk($sformatf("tbl%0d_cycle_count", i), bus.cycle_count, tbl[i].cc);
      end
      bus.div = 8'd0; bus.run = 1'b1;
      tick();
      repeat (5) begin
         tick();
         chk("div0_clk_en", bus.clk_en, 1'b1);
      end
      chk("div0_count", bus.cycle_count, 64'd8);
      bus.halt = 1'b1;
      tick();
      chk("halt_clk_en", bus.clk_en, 1'b0);
      chk("halt_running", bus.running, 1'b0);
      bus.halt = 1'b0; bus.run = 1'b0;
      repeat (3) begin
         tick();
         chk("halted_stays", bus.running, 1'b0);
      end
      bus.div = 8'd10; bus.run = 1'b1;
      tick();
      repeat (7) begin
         tick();
         chk("div10_no_pulse", bus.clk_en, 1'b0);
      end
      bus.div = 8'd3;
      tick();
      chk("div_lower_pulse", bus.clk_en, 1'b1);
      repeat (3) begin
         tick();
         chk("div3_gap", bus.clk_en, 1'b0);
      end
      tick();
      chk("div3_period", bus.clk_en, 1'b1);
      repeat (8) tick();
      chk("pre_reset_count", bus.cycle_count, 64'd12);
      reset = 1'b1;
      tick();
      chk("mid_reset_cr", bus.core_reset, 1'b1);
      chk("mid_reset_en", bus.clk_en, 1'b0);
      chk("mid_reset_cc", bus.cycle_count, 64'd0);
      chk("mid_reset_rn", bus.running, 1'b0);
      reset = 1'b0;
      for (int i = 1; i <= RH + 1; i++) begin
         tick();
         chk($sformatf("rehold%0d", i), bus.core_reset, i <= RH);
      end
      bus.run = 1'b0; bus.div = 8'd1; bus.step = 1'b1;
      repeat (6) tick();
      chk("step_held_count", bus.cycle_count, 64'd2);
      bus.step = 1'b0;
      for (int i = 0; i < 800; i++) begin
         reset = $urandom_range(0, 99) == 0;
         if ($urandom_range(0, 15) == 0) bus.div = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
         bus.halt = $urandom_range(0, 7) == 0;
         bus.step = $urandom_range(0, 3) == 0;
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
